linefill_buffer: RTL and testbench
==================================

LINEFILL_BUFFER -- requirements
Module: linefill_buffer

Interface
REQ-001 SHALL declare parameter ID_WIDTH, default 6, bits of linefill ID (entries = 2^ID_WIDTH = 64).
REQ-002 SHALL declare clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL declare rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL declare lfb_alloc_valid_i  input  1  miss allocated; entry lfb_alloc_id_i expects a line.
REQ-005 SHALL declare lfb_alloc_id_i  input  ID_WIDTH  allocated entry (set/way index).
REQ-006 SHALL declare biu_r_valid_i  input  1  read-data beat valid.
REQ-007 SHALL declare biu_r_ready_o  output  1  beat accept.
REQ-008 SHALL declare biu_r_id_i  input  ID_WIDTH  beat ID.
REQ-009 SHALL declare biu_r_data_i  input  128  beat data.
REQ-010 SHALL declare biu_r_last_i  input  1  final beat of line.
REQ-011 SHALL declare biu_isu_rvalid_o  output  1  one-cycle line-complete pulse to issue queue.
REQ-012 SHALL declare biu_isu_rid_o  output  ID_WIDTH  completed line ID.
REQ-013 SHALL declare iq_linefill_buffer_raddr_i  input  ID_WIDTH  issue-queue read address.
REQ-014 SHALL declare linefill_buffer_data_o  output  256  line at raddr; [127:0] offset0, [255:128] offset1.
REQ-015 SHALL declare lfb_err_o  output  1  sticky protocol error.

Function
REQ-016 SHALL accept a beat when biu_r_valid_i & biu_r_ready_o (beat_fire).
REQ-017 SHALL drive biu_r_ready_o from a register: 0 in reset, 1 from the first clock edge after rst_i deasserts; no other backpressure.
REQ-018 SHALL keep per-entry pending bit and 1-bit beat counter; lfb_alloc_valid_i sets pending[id]=1, beat[id]=0.
REQ-019 SHALL write a beat with beat[id]=0 into data[id][127:0] and set beat[id]=1; beat[id]=1 writes data[id][255:128] and sets beat[id]=0.
REQ-020 SHALL on beat_fire with biu_r_last_i clear pending[id] and register biu_isu_rvalid_o=1, biu_isu_rid_o=id for exactly the next cycle (latency 1 from last beat).
REQ-021 SHALL hold biu_isu_rvalid_o=0 when no last beat fired the previous cycle; biu_isu_rid_o holds its last value.
REQ-022 SHALL allow beats of different IDs to interleave on consecutive cycles; each ID tracked independently.
REQ-023 SHALL drive linefill_buffer_data_o combinationally as data[iq_linefill_buffer_raddr_i]; a same-cycle write to that entry is visible only from the next cycle.
REQ-024 SHALL guarantee data written by the last beat is readable in the cycle biu_isu_rvalid_o pulses.
REQ-025 SHALL treat alloc and beat_fire on the same ID in the same cycle as alloc first: beat lands in [127:0], beat counter ends at 1 (or 0 if last).
REQ-026 SHALL on alloc of an already pending ID restart it (beat=0).
REQ-027 SHALL not reset the data array; unwritten entries read undefined.

Reset
REQ-028 SHALL on rst_i clear pending, beat counters, biu_r_ready_o, biu_isu_rvalid_o, biu_isu_rid_o (to 0), lfb_err_o, at once regardless of clock.
REQ-029 SHALL abandon any partially received line on reset; no completion pulse after reset for it.

Configuration
REQ-030 SHALL with LFB_ERR_CHECK_EN defined set lfb_err_o (sticky until reset) on: beat_fire to non-pending ID; last with beat[id]=0; non-last with beat[id]=1; alloc of pending ID. Erroneous beats still write data per REQ-019, and completion still follows REQ-020.
REQ-031 SHALL with LFB_ERR_CHECK_EN undefined tie lfb_err_o to 0 and synthesize no check logic.

Verification
REQ-032 SHALL cover: alloc id 5; beats 5/A, 5/B(last) back-to-back -> rvalid=1, rid=5 cycle after B; raddr=5 gives {B,A} that cycle.
REQ-033 SHALL cover: interleave 3/A, 7/C, 3/B(last), 7/D(last) -> pulses rid=3 then rid=7 on consecutive cycles; lines {B,A},{D,C}.
REQ-034 SHALL cover: reset after first beat of id 9, re-alloc 9, two beats -> exactly one pulse rid=9, no spurious pulse; ready=0 during reset, 1 one edge after.
REQ-035 SHALL cover: raddr=2 while last beat of id 2 writes -> old data that cycle, new data next cycle.
REQ-036 SHALL cover (LFB_ERR_CHECK_EN): beat to unallocated id 12 -> lfb_err_o=1 next cycle and held; without macro lfb_err_o stays 0.
REQ-037 SHALL cover: same-cycle alloc id 4 with beat 4/A, then 4/B(last) -> pulse rid=4, line {B,A}, no error.

Source files
------------

// File: rtl/linefill_buffer.sv
// linefill_buffer: two-beat line assembly per ID with completion pulse; LFB_ERR_CHECK_EN adds sticky protocol-error flag
module linefill_buffer #(
  parameter int ID_WIDTH = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lfb_alloc_valid_i,
  input  logic [ID_WIDTH-1:0] lfb_alloc_id_i,
  input  logic                biu_r_valid_i,
  output logic                biu_r_ready_o,
  input  logic [ID_WIDTH-1:0] biu_r_id_i,
  input  logic [127:0]        biu_r_data_i,
  input  logic                biu_r_last_i,
  output logic                biu_isu_rvalid_o,
  output logic [ID_WIDTH-1:0] biu_isu_rid_o,
  input  logic [ID_WIDTH-1:0] iq_linefill_buffer_raddr_i,
  output logic [255:0]        linefill_buffer_data_o,
  output logic                lfb_err_o
);
  localparam int N = 1 << ID_WIDTH;
  logic [N-1:0] pending_q, pending_d, beat_q, beat_d;
  logic [127:0] lo_q [N];
  logic [127:0] hi_q [N];
  logic ready_q, rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic fire, same, cur_beat;
  assign fire = biu_r_valid_i & ready_q;
  assign same = lfb_alloc_valid_i & (lfb_alloc_id_i == biu_r_id_i);
  // a same-cycle alloc restarts the entry before the beat is applied
  assign cur_beat = !same & beat_q[biu_r_id_i];
  always_comb begin
    pending_d = pending_q;
    beat_d = beat_q;
    if (lfb_alloc_valid_i) begin
      pending_d[lfb_alloc_id_i] = 1'b1;
      beat_d[lfb_alloc_id_i] = 1'b0;
    end
    if (fire) begin
      beat_d[biu_r_id_i] = !biu_r_last_i & !cur_beat;
      pending_d[biu_r_id_i] = biu_r_last_i ? 1'b0 : pending_d[biu_r_id_i];
    end
    rvalid_d = fire & biu_r_last_i;
    rid_d = rvalid_d ? biu_r_id_i : rid_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      beat_q <= '0;
      ready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q <= '0;
    end else begin
      pending_q <= pending_d;
      beat_q <= beat_d;
      ready_q <= 1'b1;
      rvalid_q <= rvalid_d;
      rid_q <= rid_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (fire & !cur_beat) lo_q[biu_r_id_i] <= biu_r_data_i;
    if (fire & cur_beat) hi_q[biu_r_id_i] <= biu_r_data_i;
  end
  assign biu_r_ready_o = ready_q;
  assign biu_isu_rvalid_o = rvalid_q;
  assign biu_isu_rid_o = rid_q;
  assign linefill_buffer_data_o = {hi_q[iq_linefill_buffer_raddr_i], lo_q[iq_linefill_buffer_raddr_i]};
`ifdef LFB_ERR_CHECK_EN
  logic err_q, err_d;
  // last must coincide with the second beat, hence the xor
  always_comb err_d = err_q
    | (fire & (!(pending_q[biu_r_id_i] | same) | (biu_r_last_i ^ cur_beat)))
    | (lfb_alloc_valid_i & pending_q[lfb_alloc_id_i]);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign lfb_err_o = err_q;
`else
  assign lfb_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_linefill_buffer.sv
// tb_linefill_buffer: directed checks of line assembly, completion pulse, read timing, reset and error flag
module tb_linefill_buffer;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic lfb_alloc_valid_i = 1'b0, biu_r_valid_i = 1'b0, biu_r_last_i = 1'b0;
  logic [5:0] lfb_alloc_id_i = '0, biu_r_id_i = '0, iq_linefill_buffer_raddr_i = '0;
  logic [127:0] biu_r_data_i = '0;
  logic biu_r_ready_o, biu_isu_rvalid_o, lfb_err_o;
  logic [5:0] biu_isu_rid_o;
  logic [255:0] linefill_buffer_data_o;
  int n_cmp = 0, n_bad = 0;
  localparam logic [127:0] A = 128'h0A0A_0A0A_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] B = 128'h0B0B_0B0B_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] C = 128'h0C0C_0C0C_DEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D = 128'h0D0D_0D0D_FEDC_BA98_7654_3210_CAFE_F00D;
  localparam logic [127:0] E = 128'h0E0E_0E0E_1357_9BDF_2468_ACE0_1122_3344;
  localparam logic [127:0] F = 128'h0F0F_0F0F_5566_7788_99AA_BBCC_DDEE_FF00;
  localparam logic [127:0] G = 128'h1010_1010_ABCD_0000_1234_0000_5678_0000;
  localparam logic [127:0] H = 128'h2020_2020_0000_ABCD_0000_1234_0000_5678;
  localparam logic [127:0] P = 128'h3030_3030_A5A5_A5A5_5A5A_5A5A_C3C3_3C3C;
  localparam logic [127:0] Q = 128'h4040_4040_0F0F_F0F0_1E1E_E1E1_2D2D_D2D2;
  linefill_buffer #(.ID_WIDTH(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lfb_alloc_valid_i(lfb_alloc_valid_i), .lfb_alloc_id_i(lfb_alloc_id_i),
    .biu_r_valid_i(biu_r_valid_i), .biu_r_ready_o(biu_r_ready_o), .biu_r_id_i(biu_r_id_i),
    .biu_r_data_i(biu_r_data_i), .biu_r_last_i(biu_r_last_i),
    .biu_isu_rvalid_o(biu_isu_rvalid_o), .biu_isu_rid_o(biu_isu_rid_o),
    .iq_linefill_buffer_raddr_i(iq_linefill_buffer_raddr_i),
    .linefill_buffer_data_o(linefill_buffer_data_o), .lfb_err_o(lfb_err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic av, input logic [5:0] aid, input logic bv, input logic [5:0] bid,
                       input logic [127:0] d, input logic bl);
    lfb_alloc_valid_i = av;
    lfb_alloc_id_i = aid;
    biu_r_valid_i = bv;
    biu_r_id_i = bid;
    biu_r_data_i = d;
    biu_r_last_i = bl;
  endtask
  task automatic idle();
    drive(1'b0, 6'd0, 1'b0, 6'd0, '0, 1'b0);
  endtask
  task automatic pulse(input string tag, input logic [5:0] id);
    check({tag, "_rvalid"}, 256'(biu_isu_rvalid_o), 256'd1);
    check({tag, "_rid"}, 256'(biu_isu_rid_o), 256'(id));
  endtask
  logic exp_err;
  initial begin
`ifdef LFB_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tick();
    tick();
    check("rst_ready", 256'(biu_r_ready_o), 256'd0);
    check("rst_rvalid", 256'(biu_isu_rvalid_o), 256'd0);
    check("rst_rid", 256'(biu_isu_rid_o), 256'd0);
    check("rst_err", 256'(lfb_err_o), 256'd0);
    rst_i = 1'b0;
    #1;
    check("ready_before_edge", 256'(biu_r_ready_o), 256'd0);
    tick();
    check("ready_after_edge", 256'(biu_r_ready_o), 256'd1);
    // basic line for id 5
    drive(1'b1, 6'd5, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd5, A, 1'b0); tick();
    check("b5_no_early_pulse", 256'(biu_isu_rvalid_o), 256'd0);
    drive(1'b0, 6'd0, 1'b1, 6'd5, B, 1'b1); tick();
    idle();
    iq_linefill_buffer_raddr_i = 6'd5;
    #1;
    pulse("b5", 6'd5);
    check("b5_line", linefill_buffer_data_o, {B, A});
    tick();
    check("b5_pulse_end", 256'(biu_isu_rvalid_o), 256'd0);
    check("b5_rid_hold", 256'(biu_isu_rid_o), 256'd5);
    // interleaved ids 3 and 7
    drive(1'b1, 6'd3, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b1, 6'd7, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd3, A, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd7, C, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd3, B, 1'b1); tick();
    pulse("il3", 6'd3);
    drive(1'b0, 6'd0, 1'b1, 6'd7, D, 1'b1); tick();
    idle();
    pulse("il7", 6'd7);
    iq_linefill_buffer_raddr_i = 6'd3;
    #1;
    check("il3_line", linefill_buffer_data_o, {B, A});
    iq_linefill_buffer_raddr_i = 6'd7;
    #1;
    check("il7_line", linefill_buffer_data_o, {D, C});
    tick();
    check("il_pulse_end", 256'(biu_isu_rvalid_o), 256'd0);
    // read of id 2 while its last beat writes
    drive(1'b1, 6'd2, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd2, G, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd2, H, 1'b1); tick();
    drive(1'b1, 6'd2, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd2, E, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd2, F, 1'b1);
    iq_linefill_buffer_raddr_i = 6'd2;
    #1;
    check("rw2_old", linefill_buffer_data_o, {H, E});
    tick();
    idle();
    #1;
    check("rw2_new", linefill_buffer_data_o, {F, E});
    pulse("rw2", 6'd2);
    // same-cycle alloc and first beat on id 4
    drive(1'b1, 6'd4, 1'b1, 6'd4, A, 1'b0); tick();
    check("sc4_no_early_pulse", 256'(biu_isu_rvalid_o), 256'd0);
    drive(1'b0, 6'd0, 1'b1, 6'd4, B, 1'b1); tick();
    idle();
    iq_linefill_buffer_raddr_i = 6'd4;
    #1;
    pulse("sc4", 6'd4);
    check("sc4_line", linefill_buffer_data_o, {B, A});
    check("sc4_err", 256'(lfb_err_o), 256'd0);
    // reset in the middle of a line for id 9
    drive(1'b1, 6'd9, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd9, A, 1'b0); tick();
    idle();
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_ready", 256'(biu_r_ready_o), 256'd0);
    check("async_rst_rid", 256'(biu_isu_rid_o), 256'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("rst9_ready_low", 256'(biu_r_ready_o), 256'd0);
    check("rst9_no_pulse", 256'(biu_isu_rvalid_o), 256'd0);
    tick();
    check("rst9_ready_high", 256'(biu_r_ready_o), 256'd1);
    drive(1'b1, 6'd9, 1'b0, 6'd0, '0, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1, 6'd9, P, 1'b0); tick();
    check("r9_no_spurious", 256'(biu_isu_rvalid_o), 256'd0);
    drive(1'b0, 6'd0, 1'b1, 6'd9, Q, 1'b1); tick();
    idle();
    iq_linefill_buffer_raddr_i = 6'd9;
    #1;
    pulse("r9", 6'd9);
    check("r9_line", linefill_buffer_data_o, {Q, P});
    tick();
    check("r9_single_pulse", 256'(biu_isu_rvalid_o), 256'd0);
    check("r9_err", 256'(lfb_err_o), 256'd0);
    // beat to unallocated id 12
    drive(1'b0, 6'd0, 1'b1, 6'd12, C, 1'b0); tick();
    idle();
    check("err12", 256'(lfb_err_o), 256'(exp_err));
    tick();
    tick();
    check("err12_sticky", 256'(lfb_err_o), 256'(exp_err));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
